sram_1rw1r_param: RTL and testbench

//  Parametrised, synthesizable 1RW+1R SRAM with per-lane write mask for TCAM match tables.

---
 rtl/sram_1rw1r_param.sv | 168 ++++++++++++++++
 tb/tb_sram_1rw1r_param.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_1rw1r_param.sv
// 1RW+1R SRAM with per-lane write mask, post-reset zero-fill, 1- or 2-cycle read latency
// and optional write-to-read forwarding on port 1 when both ports hit the same word.
//
// state    | meaning
// ST_INIT  | zero-fill sweep, one word per clk; all requests ignored
// ST_READY | normal operation; left only through rst
module sram_1rw1r_param #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 8,
    parameter int LANE_WIDTH    = 8,
    parameter int NUM_WMASKS    = DATA_WIDTH / LANE_WIDTH,
    parameter int READ_LATENCY  = 1,
    parameter int BYPASS        = 1,
    parameter int INIT_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  csb0,
    input  logic                  web0,
    input  logic [NUM_WMASKS-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] din0,
    output logic [DATA_WIDTH-1:0] dout0,
    output logic                  rvalid0,
    input  logic                  csb1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    output logic [DATA_WIDTH-1:0] dout1,
    output logic                  rvalid1,
    output logic                  init_busy
);

    localparam int RAM_DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {ST_INIT, ST_READY} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
    logic [DATA_WIDTH-1:0]   mem_q [RAM_DEPTH];

    logic                    fill_we;
    logic                    req_ok;
    logic                    wr0, rd0, rd1;
    logic [DATA_WIDTH-1:0]   wbits;
    logic [1:0]              rd_req;
    logic [DATA_WIDTH-1:0]   rd_data [2];

    logic [1:0]              s1_v_q;
    logic [DATA_WIDTH-1:0]   s1_d_q [2];
    logic [1:0]              out_v;
    logic [DATA_WIDTH-1:0]   out_d [2];
    logic [1:0]              rvalid_q;
    logic [DATA_WIDTH-1:0]   dout_q [2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= (INIT_ON_RESET != 0) ? ST_INIT : ST_READY;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_INIT: begin
                ptr_d = ptr_q + ADDR_WIDTH'(1);
                if (ptr_q == ADDR_WIDTH'(RAM_DEPTH - 1)) state_d = ST_READY;
            end
            default: state_d = ST_READY;
        endcase
    end

    // rst gates the array too, so holding reset never disturbs stored words
    always_comb begin
        init_busy = (state_q == ST_INIT);
        fill_we   = (state_q == ST_INIT) && !rst;
        req_ok    = (state_q == ST_READY) && !rst;
    end

    assign wr0    = req_ok && !csb0 && !web0;
    assign rd0    = req_ok && !csb0 && web0;
    assign rd1    = req_ok && !csb1;
    assign rd_req = {rd1, rd0};

    always_comb begin
        wbits = '0;
        for (int i = 0; i < DATA_WIDTH; i++) wbits[i] = wmask0[i / LANE_WIDTH];
    end

    always_ff @(posedge clk) begin
        if (fill_we) begin
            mem_q[ptr_q] <= '0;
        end else if (wr0) begin
            for (int l = 0; l < NUM_WMASKS; l++) begin
                if (wmask0[l]) mem_q[addr0][l*LANE_WIDTH +: LANE_WIDTH] <= din0[l*LANE_WIDTH +: LANE_WIDTH];
            end
        end
    end

    // same-edge port-1 hit on the word being written: merge the written lanes in
    always_comb begin
        rd_data[0] = mem_q[addr0];
        rd_data[1] = mem_q[addr1];
        if (BYPASS != 0 && wr0 && addr0 == addr1)
            rd_data[1] = (din0 & wbits) | (mem_q[addr1] & ~wbits);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v_q    <= '0;
            s1_d_q[0] <= '0;
            s1_d_q[1] <= '0;
        end else begin
            s1_v_q <= rd_req;
            for (int p = 0; p < 2; p++) begin
                if (rd_req[p]) s1_d_q[p] <= rd_data[p];
            end
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic [1:0]            s2_v_q;
            logic [DATA_WIDTH-1:0] s2_d_q [2];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s2_v_q    <= '0;
                    s2_d_q[0] <= '0;
                    s2_d_q[1] <= '0;
                end else begin
                    s2_v_q <= s1_v_q;
                    for (int p = 0; p < 2; p++) begin
                        if (s1_v_q[p]) s2_d_q[p] <= s1_d_q[p];
                    end
                end
            end

            assign out_v = s2_v_q;
            assign out_d = s2_d_q;
        end else begin : g_lat1
            assign out_v = s1_v_q;
            assign out_d = s1_d_q;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid_q  <= '0;
            dout_q[0] <= '0;
            dout_q[1] <= '0;
        end else begin
            rvalid_q <= out_v;
            for (int p = 0; p < 2; p++) begin
                if (out_v[p]) dout_q[p] <= out_d[p];
            end
        end
    end

    assign dout0   = dout_q[0];
    assign dout1   = dout_q[1];
    assign rvalid0 = rvalid_q[0];
    assign rvalid1 = rvalid_q[1];

endmodule

// File: tb/tb_sram_1rw1r_param.sv
// Scoreboard bench: two instances (LAT=1/BYPASS=1 and LAT=2/BYPASS=0) share one stimulus
// stream and are compared against an array model of the memory contents.
module tb_sram_1rw1r_param;

    localparam int DW    = 32;
    localparam int AW    = 8;
    localparam int LW    = 8;
    localparam int NM    = DW / LW;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          csb0, web0, csb1;
    logic [NM-1:0] wmask0;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] din0;

    logic [DW-1:0] dout0_a, dout1_a, dout0_b, dout1_b;
    logic          rvalid0_a, rvalid1_a, rvalid0_b, rvalid1_b;
    logic          init_busy_a, init_busy_b;

    always #5 clk = ~clk;

    sram_1rw1r_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LANE_WIDTH(LW), .READ_LATENCY(1),
                       .BYPASS(1), .INIT_ON_RESET(1)) dut_a (
        .clk(clk), .rst(rst), .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0),
        .din0(din0), .dout0(dout0_a), .rvalid0(rvalid0_a), .csb1(csb1), .addr1(addr1),
        .dout1(dout1_a), .rvalid1(rvalid1_a), .init_busy(init_busy_a));

    sram_1rw1r_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LANE_WIDTH(LW), .READ_LATENCY(2),
                       .BYPASS(0), .INIT_ON_RESET(1)) dut_b (
        .clk(clk), .rst(rst), .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0),
        .din0(din0), .dout0(dout0_b), .rvalid0(rvalid0_b), .csb1(csb1), .addr1(addr1),
        .dout1(dout1_b), .rvalid1(rvalid1_b), .init_busy(init_busy_b));

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    // slot p: 0 = a.port0, 1 = a.port1, 2 = b.port0, 3 = b.port1
    exp_t          sb [4][$];
    logic [DW-1:0] last [4];
    logic [DW-1:0] model [DEPTH];
    logic          rv [4];
    logic [DW-1:0] dv [4];
    int            cyc = 0;
    int            busy_left = DEPTH;
    int            checks = 0;
    int            failures = 0;

    always_comb begin
        rv[0] = rvalid0_a; rv[1] = rvalid1_a; rv[2] = rvalid0_b; rv[3] = rvalid1_b;
        dv[0] = dout0_a;   dv[1] = dout1_a;   dv[2] = dout0_b;   dv[3] = dout1_b;
    end

    function automatic int lat_of(input int p);
        return (p < 2) ? 1 : 2;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        for (int p = 0; p < 4; p++) begin
            checks++;
            if (rst) begin
                if (rv[p] !== 1'b0 || dv[p] !== '0) begin
                    failures++;
                    $display("FAIL reset_out slot%0d: rvalid=%b dout=%h, required 0/00000000", p, rv[p], dv[p]);
                end
            end else if (rv[p] === 1'b1) begin
                if (sb[p].size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_rvalid slot%0d cyc=%0d dout=%h, required no rvalid", p, cyc, dv[p]);
                end else begin
                    e = sb[p].pop_front();
                    if (dv[p] !== e.data || cyc != e.cyc) begin
                        failures++;
                        $display("FAIL read_data slot%0d: got %h at edge %0d, required %h at edge %0d",
                                 p, dv[p], cyc, e.data, e.cyc);
                    end
                    last[p] = e.data;
                end
            end else if (rv[p] !== 1'b0 || dv[p] !== last[p]) begin
                failures++;
                $display("FAIL dout_hold slot%0d cyc=%0d: rvalid=%b dout=%h, required 0/%h", p, cyc, rv[p], dv[p], last[p]);
            end
        end
        checks += 2;
        if (init_busy_a !== (rst || busy_left > 0)) begin
            failures++;
            $display("FAIL init_busy_a cyc=%0d: got %b, required %b", cyc, init_busy_a, rst || busy_left > 0);
        end
        if (init_busy_b !== (rst || busy_left > 0)) begin
            failures++;
            $display("FAIL init_busy_b cyc=%0d: got %b, required %b", cyc, init_busy_b, rst || busy_left > 0);
        end
    end

    task automatic idle();
        csb0 = 1'b1; web0 = 1'b1; csb1 = 1'b1; wmask0 = '0; din0 = '0;
    endtask

    // Applies the current inputs to the model, then advances one clock edge.
    task automatic tick();
        logic [DW-1:0] w, old1;
        if (!rst && busy_left == 0) begin
            if (!csb0 && web0) begin
                sb[0].push_back('{model[addr0], cyc + 1 + lat_of(0)});
                sb[2].push_back('{model[addr0], cyc + 1 + lat_of(2)});
            end
            if (!csb1) begin
                old1 = model[addr1];
                w    = old1;
                if (!csb0 && !web0 && addr0 == addr1) begin
                    for (int l = 0; l < NM; l++) if (wmask0[l]) w[l*LW +: LW] = din0[l*LW +: LW];
                end
                sb[1].push_back('{w, cyc + 1 + lat_of(1)});
                sb[3].push_back('{old1, cyc + 1 + lat_of(3)});
            end
            if (!csb0 && !web0) begin
                w = model[addr0];
                for (int l = 0; l < NM; l++) if (wmask0[l]) w[l*LW +: LW] = din0[l*LW +: LW];
                model[addr0] = w;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (!rst && busy_left > 0) busy_left--;
    endtask

    task automatic assert_rst();
        rst = 1'b1;
        for (int p = 0; p < 4; p++) begin
            sb[p].delete();
            last[p] = '0;
        end
    endtask

    task automatic release_rst();
        rst = 1'b0;
        busy_left = DEPTH;
        for (int a = 0; a < DEPTH; a++) model[a] = '0;
    endtask

    task automatic run_until_ready();
        for (int i = 0; i < DEPTH + 4 && busy_left > 0; i++) tick();
    endtask

    initial begin
        for (int p = 0; p < 4; p++) last[p] = '0;
        rst = 1'b1; addr0 = '0; addr1 = '0;
        idle();
        repeat (3) tick();
        release_rst();

        // requests during zero-fill must be dropped
        csb1 = 1'b0; addr1 = 8'h05;
        tick();
        idle();
        csb0 = 1'b0; web0 = 1'b0; addr0 = 8'h33; din0 = 32'hFFFF_FFFF; wmask0 = '1;
        tick();
        idle();
        run_until_ready();

        for (int a = 0; a < DEPTH; a++) begin
            csb1 = 1'b0; addr1 = AW'(a);
            csb0 = 1'b0; web0 = 1'b1; addr0 = AW'(DEPTH - 1 - a);
            tick();
        end
        idle();

        csb0 = 1'b0; web0 = 1'b0; addr0 = 8'h10; din0 = 32'hDEAD_BEEF; wmask0 = 4'b0101;
        tick();
        idle();
        csb0 = 1'b0; web0 = 1'b1; addr0 = 8'h10;
        tick();
        idle();
        repeat (3) tick();

        csb0 = 1'b0; web0 = 1'b0; addr0 = 8'h20; din0 = 32'hA5A5_A5A5; wmask0 = 4'b1111;
        csb1 = 1'b0; addr1 = 8'h20;
        tick();
        idle();
        csb0 = 1'b0; web0 = 1'b1; addr0 = 8'h33;
        tick();
        idle();
        repeat (3) tick();

        for (int a = 0; a < 8; a++) begin
            csb0 = 1'b0; web0 = 1'b1; addr0 = AW'(a);
            csb1 = 1'b0; addr1 = AW'(a);
            tick();
        end
        idle();
        repeat (5) tick();

        for (int i = 0; i < 1500; i++) begin
            csb0   = ($urandom_range(0, 3) == 0);
            web0   = $urandom_range(0, 1) != 0;
            wmask0 = NM'($urandom_range(0, (1 << NM) - 1));
            addr0  = AW'($urandom_range(0, 15));
            din0   = $urandom();
            csb1   = ($urandom_range(0, 9) < 3);
            addr1  = AW'($urandom_range(0, 15));
            tick();
        end
        idle();
        repeat (4) tick();

        // reset in the middle of the fill restarts the full sweep
        assert_rst();
        tick();
        release_rst();
        repeat (100) tick();
        assert_rst();
        repeat (2) tick();
        release_rst();
        run_until_ready();

        csb0 = 1'b0; web0 = 1'b0; addr0 = 8'h40; din0 = 32'h1234_5678; wmask0 = '1;
        tick();
        csb0 = 1'b0; web0 = 1'b1; addr0 = 8'h40; csb1 = 1'b0; addr1 = 8'h40;
        tick();
        idle();
        assert_rst();
        repeat (2) tick();
        release_rst();
        run_until_ready();

        csb0 = 1'b0; web0 = 1'b1; addr0 = 8'h40; csb1 = 1'b0; addr1 = 8'h10;
        tick();
        idle();
        repeat (6) tick();

        for (int p = 0; p < 4; p++) begin
            checks++;
            if (sb[p].size() != 0) begin
                failures++;
                $display("FAIL missing_reads slot%0d: %0d outstanding, required 0", p, sb[p].size());
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
